// File: rtl/move_input_conditioner.sv
// Synchronises and debounces four direction buttons and hands out one press at a time.
// Press-to-move latency SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles; extra presses while a move is pending are dropped (overflow).
module move_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic [3:0] held,
  output logic       overflow
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]             w_raw;
  logic [SYNC_STAGES-1:0] r_sync [4];
  logic [CNT_W-1:0]       r_cnt  [4];
  logic [3:0]             r_stable;
  logic [3:0]             r_stable_d;
  logic [3:0]             r_press;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_dir, w_dir_nxt;
  logic       r_ovf, w_ovf_set;
  logic [1:0] w_win;
  logic       w_any;
  logic       w_multi;

  assign w_raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_stable   <= '0;
      r_stable_d <= '0;
      r_press    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
        // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
        if (r_sync[i][SYNC_STAGES-1] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
    end
  end

  // Fixed priority up > down > left > right; any other simultaneous press is a loser.
  always_comb begin
    w_win = 2'd3;
    if (r_press[0])      w_win = 2'd0;
    else if (r_press[1]) w_win = 2'd1;
    else if (r_press[2]) w_win = 2'd2;
    w_any   = |r_press;
    w_multi = |(r_press & (r_press - 4'd1));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_ovf_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = PENDING;
          w_dir_nxt   = w_win;
          w_ovf_set   = w_multi;
        end
      end
      PENDING: begin
        if (move_ready) begin
          if (w_any) begin
            w_dir_nxt = w_win;
            w_ovf_set = w_multi;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_any) begin
          w_ovf_set = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dir   <= 2'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_ovf   <= r_ovf | w_ovf_set;
    end
  end

  assign move_valid = (r_state == PENDING);
  assign move_dir   = r_dir;
  assign held       = r_stable;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_move_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready = 1'b0;
  logic [3:0] held;
  logic       overflow;

  int tests  = 0;
  int failed = 0;

  move_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .held(held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Leaves inputs changed just after an edge, so the next posedge is "edge 0".
  task automatic do_reset();
    rst = 1'b1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    move_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_up = 1'b1; btn_right = 1'b1; move_ready = 1'b1;
    step(3);
    tests++;
    if ({move_valid, move_dir, held, overflow} !== 8'b0) begin
      failed++;
      $display("FAIL reset_state: got v=%b d=%b h=%b o=%b, want all 0", move_valid, move_dir, held, overflow);
    end
  endtask

  task automatic test_single_up();
    do_reset();
    btn_up = 1'b1; move_ready = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step(1);
      tests++;
      if (move_valid !== (k == 7)) begin
        failed++;
        $display("FAIL up_valid_edge%0d: got %b want %b", k, move_valid, (k == 7));
      end
      if (k == 7) begin
        tests++;
        if (move_dir !== 2'b00) begin
          failed++;
          $display("FAIL up_dir: got %b want 00", move_dir);
        end
      end
      if (k == 4 || k == 5) begin
        tests++;
        if (held !== ((k == 5) ? 4'b0001 : 4'b0000)) begin
          failed++;
          $display("FAIL up_held_edge%0d: got %b", k, held);
        end
      end
    end
    btn_up = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step(1);
      tests++;
      if (move_valid !== 1'b0) begin
        failed++;
        $display("FAIL release_no_move_edge%0d: got %b want 0", k, move_valid);
      end
    end
    tests++;
    if (held !== 4'b0000 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL release_state: held=%b ovf=%b want 0000 0", held, overflow);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    move_ready = 1'b1;
    btn_left = 1'b1;
    step(3);
    btn_left = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step(1);
      tests++;
      if (move_valid !== 1'b0 || held !== 4'b0000 || overflow !== 1'b0) begin
        failed++;
        $display("FAIL glitch_edge%0d: v=%b h=%b o=%b want 0 0000 0", k, move_valid, held, overflow);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    move_ready = 1'b1;
    btn_down = 1'b1; btn_right = 1'b1;
    step(8);
    tests++;
    if (move_valid !== 1'b1 || move_dir !== 2'b01 || overflow !== 1'b1 || held !== 4'b1010) begin
      failed++;
      $display("FAIL simul_move: v=%b d=%b o=%b h=%b want 1 01 1 1010", move_valid, move_dir, overflow, held);
    end
    step(1);
    tests++;
    if (move_valid !== 1'b0) begin
      failed++;
      $display("FAIL simul_single: got v=%b want 0", move_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    btn_right = 1'b1;
    step(8);
    tests++;
    if (move_valid !== 1'b1 || move_dir !== 2'b11 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL bp_right: v=%b d=%b o=%b want 1 11 0", move_valid, move_dir, overflow);
    end
    btn_right = 1'b0;
    step(8);
    btn_up = 1'b1;
    step(9);
    tests++;
    if (move_valid !== 1'b1 || move_dir !== 2'b11 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL bp_discard: v=%b d=%b o=%b want 1 11 1", move_valid, move_dir, overflow);
    end
    move_ready = 1'b1;
    step(1);
    tests++;
    if (move_valid !== 1'b0) begin
      failed++;
      $display("FAIL bp_transfer: got v=%b want 0", move_valid);
    end
    step(3);
    tests++;
    if (move_valid !== 1'b0 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL bp_idle: v=%b o=%b want 0 1", move_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    btn_up = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step(1);
      if (k == 2) btn_left = 1'b1;
      if (k == 9) move_ready = 1'b1;
      if (k == 7 || k == 9) begin
        tests++;
        if (move_valid !== 1'b1 || move_dir !== 2'b00) begin
          failed++;
          $display("FAIL b2b_first_edge%0d: v=%b d=%b want 1 00", k, move_valid, move_dir);
        end
      end
      if (k == 10) begin
        tests++;
        if (move_valid !== 1'b1 || move_dir !== 2'b10 || overflow !== 1'b0) begin
          failed++;
          $display("FAIL b2b_second: v=%b d=%b o=%b want 1 10 0", move_valid, move_dir, overflow);
        end
      end
      if (k == 11) begin
        tests++;
        if (move_valid !== 1'b0) begin
          failed++;
          $display("FAIL b2b_drain: got v=%b want 0", move_valid);
        end
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    btn_down = 1'b1; btn_left = 1'b1;
    step(8);
    tests++;
    if (move_valid !== 1'b1 || overflow !== 1'b1 || held !== 4'b0110) begin
      failed++;
      $display("FAIL rstp_setup: v=%b o=%b h=%b want 1 1 0110", move_valid, overflow, held);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    tests++;
    if (move_valid !== 1'b0 || overflow !== 1'b0 || held !== 4'b0000) begin
      failed++;
      $display("FAIL rstp_cleared: v=%b o=%b h=%b want 0 0 0000", move_valid, overflow, held);
    end
    // Buttons still held: they reappear as new presses after the full delay.
    step(7);
    tests++;
    if (move_valid !== 1'b0) begin
      failed++;
      $display("FAIL rstp_early: got v=%b want 0", move_valid);
    end
    step(1);
    tests++;
    if (move_valid !== 1'b1 || move_dir !== 2'b01 || overflow !== 1'b1) begin
      failed++;
      $display("FAIL rstp_repress: v=%b d=%b o=%b want 1 01 1", move_valid, move_dir, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_glitch();
    test_simultaneous();
    test_backpressure();
    test_back_to_back();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
